stream_width_down: RTL and testbench



---
 rtl/stream_width_down_pkg.sv | 29 ++
 rtl/stream_width_down.sv | 103 ++++++++++
 tb/tb_stream_width_down.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_width_down_pkg.sv
// Shared types and helpers for stream_width_down: FSM state, beat-slice
// offset selection and beat-count clamping.
package stream_width_down_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Counter width that can hold ratio-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Bit offset of beat idx inside the wide word.
  function automatic int unsigned slice_offset(input int unsigned idx,
                                               input int unsigned ratio,
                                               input int unsigned out_width,
                                               input bit          lsb_first);
    return lsb_first ? idx * out_width : (ratio - 1 - idx) * out_width;
  endfunction

  // Saturate a requested "beats minus one" to the last beat of the word.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/stream_width_down.sv
// Wide-to-narrow stream splitter feeding a narrow CDC; sends len+1 beats per word.
// Optional macro STREAM_WIDTH_DOWN_PARITY_EN adds out_parity_o (XOR of out_data_o).
module stream_width_down
  import stream_width_down_pkg::*;
#(
  parameter int unsigned  IN_WIDTH  = 64,
  parameter int unsigned  OUT_WIDTH = 16,
  parameter bit           LSB_FIRST = 1'b1,
  localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int unsigned CntW      = cnt_width(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic [CntW-1:0]      in_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [CntW-1:0]      out_idx_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
`ifdef STREAM_WIDTH_DOWN_PARITY_EN
  ,
  output logic                 out_parity_o
`endif
);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
    $error("stream_width_down: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [CntW-1:0]      len_q;
  logic [IN_WIDTH-1:0]  data_q;
  logic                 send;
  logic                 last;
  logic [CntW-1:0]      len_clamped;
  logic [OUT_WIDTH-1:0] beat_slices [RATIO];

  assign send        = (state_q == SEND);
  assign last        = send && (cnt_q == len_q);
  assign len_clamped = CntW'(clamp_len(int'(in_len_i), RATIO - 1));

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign beat_slices[g] = data_q[slice_offset(g, RATIO, OUT_WIDTH, LSB_FIRST) +: OUT_WIDTH];
  end

  // Beat-side outputs are gated by the registered state so IDLE shows all zeros.
  assign out_valid_o = send;
  assign busy_o      = send;
  assign out_last_o  = last;
  assign out_idx_o   = send ? cnt_q : '0;
  assign out_data_o  = send ? beat_slices[cnt_q] : '0;

  // Accepting a new word on the last handshake gives bubble-free back-to-back words.
  assign in_ready_o  = rst_ni && (!send || (out_ready_i && last));

`ifdef STREAM_WIDTH_DOWN_PARITY_EN
  assign out_parity_o = ^out_data_o;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q  <= in_data_i;
            len_q   <= len_clamped;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready_i) begin
            if (last) begin
              if (in_valid_i) begin
                data_q <= in_data_i;
                len_q  <= len_clamped;
                cnt_q  <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_width_down.sv
// Directed self-checking bench for stream_width_down (64->16 LSB-first and
// 48->16 MSB-first instances); parity checks when STREAM_WIDTH_DOWN_PARITY_EN is set.
module tb_stream_width_down;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [63:0] in_data;
  logic [1:0]  in_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [47:0] c_in_data;
  logic [1:0]  c_in_len;
  logic        c_in_valid;
  logic        c_in_ready;
  logic [15:0] c_out_data;
  logic [1:0]  c_out_idx;
  logic        c_out_last;
  logic        c_out_valid;
  logic        c_out_ready;
  logic        c_busy;

`ifdef STREAM_WIDTH_DOWN_PARITY_EN
  logic        out_parity;
  logic        c_out_parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_width_down #(.IN_WIDTH(64), .OUT_WIDTH(16), .LSB_FIRST(1'b1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (in_data),
    .in_len_i    (in_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
`ifdef STREAM_WIDTH_DOWN_PARITY_EN
    ,
    .out_parity_o(out_parity)
`endif
  );

  stream_width_down #(.IN_WIDTH(48), .OUT_WIDTH(16), .LSB_FIRST(1'b0)) dut_c (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (c_in_data),
    .in_len_i    (c_in_len),
    .in_valid_i  (c_in_valid),
    .in_ready_o  (c_in_ready),
    .out_data_o  (c_out_data),
    .out_idx_o   (c_out_idx),
    .out_last_o  (c_out_last),
    .out_valid_o (c_out_valid),
    .out_ready_i (c_out_ready),
    .busy_o      (c_busy)
`ifdef STREAM_WIDTH_DOWN_PARITY_EN
    ,
    .out_parity_o(c_out_parity)
`endif
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_data !== 16'h0) $display("FAIL rst_data got %h exp 0000", out_data); else n_pass++;
    n_checks++; if (out_idx !== 2'd0) $display("FAIL rst_idx got %0d exp 0", out_idx); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL rst_last got %b exp 0", out_last); else n_pass++;
    n_checks++; if (c_out_valid !== 1'b0) $display("FAIL rst_c_valid got %b exp 0", c_out_valid); else n_pass++;
`ifdef STREAM_WIDTH_DOWN_PARITY_EN
    n_checks++; if (out_parity !== 1'b0) $display("FAIL rst_parity got %b exp 0", out_parity); else n_pass++;
`endif
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b exp 1", in_ready); else n_pass++;
    cyc();
  endtask

  task automatic test_basic();
    logic [15:0] exp_beats [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    in_data   = 64'h4444_3333_2222_1111;
    in_len    = 2'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle_ready got %b exp 1", in_ready); else n_pass++;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %b exp 1", i, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_beats[i]) $display("FAIL basic_data[%0d] got %h exp %h", i, out_data, exp_beats[i]); else n_pass++;
      n_checks++; if (out_idx !== 2'(i)) $display("FAIL basic_idx[%0d] got %0d exp %0d", i, out_idx, i); else n_pass++;
      n_checks++; if (out_last !== (i == 3)) $display("FAIL basic_last[%0d] got %b exp %b", i, out_last, i == 3); else n_pass++;
      n_checks++; if (in_ready !== (i == 3)) $display("FAIL basic_in_ready[%0d] got %b exp %b", i, in_ready, i == 3); else n_pass++;
      cyc();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_end_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_end_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_beats [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic        pat [7]       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int          hs = 0;
    in_data  = 64'h4444_3333_2222_1111;
    in_len   = 2'd3;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k];
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", k, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_beats[hs]) $display("FAIL bp_data[%0d] got %h exp %h", k, out_data, exp_beats[hs]); else n_pass++;
      n_checks++; if (in_ready !== (pat[k] && hs == 3)) $display("FAIL bp_in_ready[%0d] got %b exp %b", k, in_ready, pat[k] && hs == 3); else n_pass++;
      if (pat[k]) hs++;
      cyc();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_end_valid got %b exp 0 (handshakes %0d)", out_valid, hs); else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_data   = 64'hAAAA_BBBB_CCCC_DDDD;
    in_len    = 2'd1;
    in_valid  = 1'b1;
    cyc();
    in_data = 64'h0123_4567_89AB_CDEF;
    in_len  = 2'd0;
    #1;
    n_checks++; if (out_data !== 16'hDDDD) $display("FAIL b2b_a0_data got %h exp dddd", out_data); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL b2b_a0_last got %b exp 0", out_last); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_a0_in_ready got %b exp 0", in_ready); else n_pass++;
    cyc();
    n_checks++; if (out_data !== 16'hCCCC) $display("FAIL b2b_a1_data got %h exp cccc", out_data); else n_pass++;
    n_checks++; if (out_last !== 1'b1) $display("FAIL b2b_a1_last got %b exp 1", out_last); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_a1_in_ready got %b exp 1", in_ready); else n_pass++;
    cyc();
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_b0_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'hCDEF) $display("FAIL b2b_b0_data got %h exp cdef", out_data); else n_pass++;
    n_checks++; if (out_idx !== 2'd0) $display("FAIL b2b_b0_idx got %0d exp 0", out_idx); else n_pass++;
    n_checks++; if (out_last !== 1'b1) $display("FAIL b2b_b0_last got %b exp 1", out_last); else n_pass++;
    cyc();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_clamp();
    logic [15:0] exp_beats [3] = '{16'h4444, 16'h5555, 16'h6666};
    c_in_data   = 48'h4444_5555_6666;
    c_in_len    = 2'd3;
    c_in_valid  = 1'b1;
    c_out_ready = 1'b1;
    cyc();
    c_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (c_out_valid !== 1'b1) $display("FAIL clamp_valid[%0d] got %b exp 1", i, c_out_valid); else n_pass++;
      n_checks++; if (c_out_data !== exp_beats[i]) $display("FAIL clamp_data[%0d] got %h exp %h", i, c_out_data, exp_beats[i]); else n_pass++;
      n_checks++; if (c_out_idx !== 2'(i)) $display("FAIL clamp_idx[%0d] got %0d exp %0d", i, c_out_idx, i); else n_pass++;
      n_checks++; if (c_out_last !== (i == 2)) $display("FAIL clamp_last[%0d] got %b exp %b", i, c_out_last, i == 2); else n_pass++;
      cyc();
    end
    n_checks++; if (c_out_valid !== 1'b0) $display("FAIL clamp_end_valid got %b exp 0", c_out_valid); else n_pass++;
    n_checks++; if (c_busy !== 1'b0) $display("FAIL clamp_end_busy got %b exp 0", c_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    in_data   = 64'h4444_3333_2222_1111;
    in_len    = 2'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    n_checks++; if (out_data !== 16'h2222) $display("FAIL mid_beat1_data got %h exp 2222", out_data); else n_pass++;
    rst_n = 1'b0;
    cyc();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_release_in_ready got %b exp 1", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale_valid[%0d] got %b exp 0", i, out_valid); else n_pass++;
    end
  endtask

`ifdef STREAM_WIDTH_DOWN_PARITY_EN
  task automatic test_parity();
    in_data   = 64'h0000_0000_0003_0007;
    in_len    = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_checks++; if (out_parity !== 1'b1) $display("FAIL par_0007 got %b exp 1", out_parity); else n_pass++;
    cyc();
    n_checks++; if (out_parity !== 1'b0) $display("FAIL par_0003 got %b exp 0", out_parity); else n_pass++;
    cyc();
    n_checks++; if (out_parity !== 1'b0) $display("FAIL par_idle got %b exp 0", out_parity); else n_pass++;
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_len      = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    c_in_data   = '0;
    c_in_len    = '0;
    c_in_valid  = 1'b0;
    c_out_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_clamp();
    test_reset_mid_word();
`ifdef STREAM_WIDTH_DOWN_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
